// File: rtl/cache_fill_fsm.sv
// Purpose: cache miss fill engine; fetches the 8-word aligned block and streams it into the data/tag arrays.
// Latency: busy and first read the cycle after the miss is sampled; done on the 8th returned word.
// Backpressure: none from memory; waits in FILL indefinitely for returns, stalls the CPU via fsm_busy.
module cache_fill_fsm #(
  parameter int BLOCK_WORDS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        miss_detected,
  input  logic [15:0] miss_address,
  output logic        fsm_busy,
  output logic        mem_read,
  output logic [15:0] mem_addr,
  input  logic        mem_data_valid,
  input  logic [15:0] mem_data,
  output logic        data_we,
  output logic [15:0] fill_addr,
  output logic [15:0] fill_data,
  output logic        tag_we
);

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  localparam logic [3:0] NUM_WORDS = 4'(BLOCK_WORDS);
  localparam logic [3:0] LAST_WORD = 4'(BLOCK_WORDS - 1);

  state_t      state_q, state_d;
  logic [15:0] base_q, base_d;
  logic [3:0]  issue_cnt_q, issue_cnt_d;
  logic [3:0]  recv_cnt_q, recv_cnt_d;

  logic        in_fill;
  logic        issue_now;
  logic        recv_now;
  logic        last_recv;
  logic [15:0] issue_off;
  logic [15:0] recv_off;

  // Decode of current state; miss_detected never reaches any output.
  always_comb begin
    in_fill   = (state_q == FILL);
    issue_now = in_fill && (issue_cnt_q < NUM_WORDS);
    recv_now  = in_fill && mem_data_valid;
    last_recv = recv_now && (recv_cnt_q == LAST_WORD);
    // Offsets stay within the low nibble, so adding to an aligned base never carries.
    issue_off = {12'h000, issue_cnt_q[2:0], 1'b0};
    recv_off  = {12'h000, recv_cnt_q[2:0], 1'b0};
  end

  // Output drive: everything is zero outside FILL, including during reset.
  always_comb begin
    fsm_busy  = in_fill;
    mem_read  = issue_now;
    mem_addr  = in_fill ? (base_q + issue_off) : 16'h0000;
    data_we   = recv_now;
    fill_addr = recv_now ? (base_q + recv_off) : 16'h0000;
    fill_data = recv_now ? mem_data : 16'h0000;
    tag_we    = last_recv;
  end

  // Next-state: capture aligned base on a miss, count issues/returns, exit on the last return.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    issue_cnt_d = issue_cnt_q;
    recv_cnt_d  = recv_cnt_q;
    case (state_q)
      IDLE: begin
        if (miss_detected) begin
          base_d      = miss_address & 16'hFFF0;
          issue_cnt_d = 4'd0;
          recv_cnt_d  = 4'd0;
          state_d     = FILL;
        end
      end
      FILL: begin
        if (issue_now) begin
          issue_cnt_d = issue_cnt_q + 4'd1;
        end
        if (recv_now) begin
          recv_cnt_d = recv_cnt_q + 4'd1;
        end
        if (last_recv) begin
          issue_cnt_d = 4'd0;
          recv_cnt_d  = 4'd0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset mid-fill abandons the block without a tag write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      base_q      <= 16'h0000;
      issue_cnt_q <= 4'd0;
      recv_cnt_q  <= 4'd0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
    end
  end

endmodule
